// File: rtl/systolic_popcount_pe.sv
// Binary-CNN systolic PE: XNOR-popcount of activations vs stationary weights, added to a partial sum.
// Optional per-lane mask port enabled by defining SYSTOLIC_PE_LANE_MASK_EN.
module systolic_popcount_pe #(
  parameter int LANES     = 8,
  parameter int SUM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 weight_load,
  input  logic [LANES-1:0]     weight_in,
`ifdef SYSTOLIC_PE_LANE_MASK_EN
  input  logic [LANES-1:0]     lane_mask,
`endif
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES-1:0]     act_in,
  input  logic                 last_in,
  input  logic [SUM_WIDTH-1:0] partial_sum_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_WIDTH-1:0] partial_sum_out,
  output logic [LANES-1:0]     act_out,
  output logic                 last_out,
  output logic                 sat_out
);

  localparam int PW = $clog2(LANES + 1);
  localparam int EW = SUM_WIDTH + 2;
  localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;

  // Returns {saturated, clamped value}.
  function automatic logic [SUM_WIDTH:0] sat_clamp(input logic [EW-1:0] x);
    if (x > EW'(SUM_MAX)) sat_clamp = {1'b1, SUM_MAX};
    else                  sat_clamp = {1'b0, x[SUM_WIDTH-1:0]};
  endfunction

  logic [LANES-1:0]     weight_q;
  logic [LANES-1:0]     lane_en;
  logic                 vld_p1_q, vld_p2_q;
  logic [PW-1:0]        pop_p1_q;
  logic [SUM_WIDTH-1:0] psum_p1_q;
  logic [LANES-1:0]     act_p1_q;
  logic                 last_p1_q, mode_p1_q;
  logic [SUM_WIDTH-1:0] sum_p2_q;
  logic [LANES-1:0]     act_p2_q;
  logic                 last_p2_q, sat_p2_q;
  logic [SUM_WIDTH-1:0] acc_q;
  logic                 acc_ovf_q;

`ifdef SYSTOLIC_PE_LANE_MASK_EN
  logic [LANES-1:0]     mask_q;
  assign lane_en = mask_q;
`else
  assign lane_en = '1;
`endif

  logic                 adv1, adv2, accept, emit;
  logic [LANES-1:0]     match;
  logic [PW-1:0]        pop_d;
  logic [EW-1:0]        acc_term, sum_ext, acc_ext;
  logic [SUM_WIDTH:0]   sum_cl, acc_cl;
  logic                 sat_d;

  assign adv2      = !vld_p2_q || out_ready;
  assign adv1      = !vld_p1_q || adv2;
  assign in_ready  = adv1;
  assign accept    = in_valid && adv1;
  assign out_valid = vld_p2_q;

  assign match = ~(act_in ^ weight_q) & lane_en;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < LANES; i++) pop_d = pop_d + PW'(match[i]);
  end

  // Pass-through beats ignore the accumulator entirely.
  assign emit     = !mode_p1_q || last_p1_q;
  assign acc_term = mode_p1_q ? EW'(acc_q) : '0;
  assign sum_ext  = EW'(psum_p1_q) + acc_term + EW'(pop_p1_q);
  assign acc_ext  = EW'(acc_q) + EW'(pop_p1_q);
  assign sum_cl   = sat_clamp(sum_ext);
  assign acc_cl   = sat_clamp(acc_ext);
  assign sat_d    = sum_cl[SUM_WIDTH] || (mode_p1_q && acc_ovf_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weight_q  <= '0;
`ifdef SYSTOLIC_PE_LANE_MASK_EN
      mask_q    <= '1;
`endif
      vld_p1_q  <= 1'b0;
      pop_p1_q  <= '0;
      psum_p1_q <= '0;
      act_p1_q  <= '0;
      last_p1_q <= 1'b0;
      mode_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      sum_p2_q  <= '0;
      act_p2_q  <= '0;
      last_p2_q <= 1'b0;
      sat_p2_q  <= 1'b0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else begin
      if (weight_load) begin
        weight_q <= weight_in;
`ifdef SYSTOLIC_PE_LANE_MASK_EN
        mask_q   <= lane_mask;
`endif
      end
      // Stage 1: popcount and operand capture
      if (adv1) begin
        vld_p1_q <= in_valid;
        if (accept) begin
          pop_p1_q  <= pop_d;
          psum_p1_q <= partial_sum_in;
          act_p1_q  <= act_in;
          last_p1_q <= last_in;
          mode_p1_q <= mode;
        end
      end
      // Stage 2: sum / accumulate and output register
      if (adv2) begin
        vld_p2_q <= vld_p1_q && emit;
        if (vld_p1_q) begin
          if (emit) begin
            sum_p2_q  <= sum_cl[SUM_WIDTH-1:0];
            act_p2_q  <= act_p1_q;
            last_p2_q <= last_p1_q;
            sat_p2_q  <= sat_d;
            if (mode_p1_q) begin
              acc_q     <= '0;
              acc_ovf_q <= 1'b0;
            end
          end else begin
            acc_q     <= acc_cl[SUM_WIDTH-1:0];
            acc_ovf_q <= acc_ovf_q || acc_cl[SUM_WIDTH];
          end
        end
      end
    end
  end

  assign partial_sum_out = sum_p2_q;
  assign act_out         = act_p2_q;
  assign last_out        = last_p2_q;
  assign sat_out         = sat_p2_q;

endmodule

// File: tb/tb_systolic_popcount_pe.sv
// Scoreboard bench for systolic_popcount_pe: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_systolic_popcount_pe;

  localparam int LANES = 8;
  localparam int SW    = 8;
  localparam int SMAX  = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          weight_load = 1'b0;
  logic [7:0]    weight_in = '0;
`ifdef SYSTOLIC_PE_LANE_MASK_EN
  logic [7:0]    lane_mask = '1;
`endif
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    act_in = '0;
  logic          last_in = 1'b0;
  logic [7:0]    partial_sum_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    partial_sum_out;
  logic [7:0]    act_out;
  logic          last_out;
  logic          sat_out;

  systolic_popcount_pe #(.LANES(LANES), .SUM_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .weight_load(weight_load), .weight_in(weight_in),
`ifdef SYSTOLIC_PE_LANE_MASK_EN
    .lane_mask(lane_mask),
`endif
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in),
    .last_in(last_in), .partial_sum_in(partial_sum_in), .out_valid(out_valid),
    .out_ready(out_ready), .partial_sum_out(partial_sum_out), .act_out(act_out),
    .last_out(last_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sum;
    bit         sat;
    logic [7:0] act;
    bit         last;
    bit         lat;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic [7:0] model_w = '0;
  int         model_acc = 0;
  bit         model_ovf = 0;

  task automatic chk(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference: the weights in effect when a beat is accepted, saturating sums, sticky acc overflow.
  task automatic model_accept(input logic [7:0] a, input int ps, input bit m, input bit l,
                              input int exp_sum, input bit exp_sat, input bit lat);
    int   pop, total;
    bit   sat, emit;
    exp_t e;
    logic [7:0] x;
    x     = ~(a ^ model_w);
    pop   = $countones(x);
    emit  = 0;
    total = 0;
    sat   = 0;
    if (!m) begin
      total = ps + pop;
      emit  = 1;
    end else if (!l) begin
      model_acc = model_acc + pop;
      if (model_acc > SMAX) begin
        model_acc = SMAX;
        model_ovf = 1;
      end
    end else begin
      total = ps + model_acc + pop;
      sat   = model_ovf;
      model_acc = 0;
      model_ovf = 0;
      emit  = 1;
    end
    if (emit) begin
      if (total > SMAX) begin
        total = SMAX;
        sat   = 1;
      end
      e.sum  = (exp_sum >= 0) ? exp_sum : total;
      e.sat  = (exp_sum >= 0) ? exp_sat : sat;
      e.act  = a;
      e.last = l;
      e.lat  = lat;
      e.cyc  = cyc;
      q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic beat(input logic [7:0] a, input int ps, input bit m, input bit l,
                      input bit wl, input logic [7:0] wi,
                      input int exp_sum, input bit exp_sat, input bit lat);
    bit done;
    done = 0;
    act_in = a; partial_sum_in = ps[7:0]; mode = m; last_in = l;
    weight_load = wl; weight_in = wi; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(a, ps, m, l, exp_sum, exp_sat, lat);
        done = 1;
      end
      if (wl) model_w = wi;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    weight_load = 1'b0;
  endtask

  task automatic load_w(input logic [7:0] w);
    weight_load = 1'b1; weight_in = w; in_valid = 1'b0;
    @(negedge clk);
    model_w = w;
    @(posedge clk);
    #1;
    weight_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops expectations on each completed result, checks holds and reset state.
  initial begin
    bit   hold_pend;
    int   held;
    exp_t e;
    hold_pend = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_outputs", {out_valid, partial_sum_out, act_out, last_out, sat_out}, 0);
        hold_pend = 0;
      end else begin
        if (hold_pend)
          chk("hold_stable", {out_valid, partial_sum_out, act_out, last_out, sat_out}, held);
        hold_pend = 0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = q.pop_front();
            chk("sum", partial_sum_out, e.sum);
            chk("sat", sat_out, e.sat);
            chk("act_out", act_out, e.act);
            chk("last_out", last_out, e.last);
            if (e.lat) chk("latency", cyc - e.cyc, 2);
          end
        end else if (out_valid) begin
          hold_pend = 1;
          held = {out_valid, partial_sum_out, act_out, last_out, sat_out};
        end
      end
    end
  end

  initial begin
    int r;
    #2 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // pass-through
    load_w(8'hF0);
    beat(8'hF0, 3, 0, 0, 0, 8'h00, 11, 0, 1);
    beat(8'h0F, 3, 0, 0, 0, 8'h00, 3, 0, 0);
    idle(3);

    // accumulate, one result expected
    load_w(8'hFF);
    beat(8'hFF, 0, 1, 0, 0, 8'h00, -1, 0, 0);
    beat(8'h0F, 0, 1, 0, 0, 8'h00, -1, 0, 0);
    beat(8'h01, 10, 1, 1, 0, 8'h00, 23, 0, 0);
    idle(3);

    // single-beat accumulate equals pass-through
    beat(8'h0F, 7, 1, 1, 0, 8'h00, 11, 0, 0);
    beat(8'h0F, 7, 0, 0, 0, 8'h00, 11, 0, 0);

    // saturation then clean
    beat(8'hFF, 250, 0, 0, 0, 8'h00, 255, 1, 0);
    beat(8'h00, 5, 0, 0, 0, 8'h00, 5, 0, 0);
    idle(3);

    // back-pressure
    fork
      begin
        for (int i = 0; i < 5; i++) beat(8'(i * 37), 10 * i, 0, 0, 0, 8'h00, -1, 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("in_ready_stalled", in_ready, 0);
        rdy_mode = 0;
      end
    join
    idle(4);

    // weight load colliding with an accepted beat
    beat(8'hFF, 0, 0, 0, 1, 8'h00, 8, 0, 0);
    beat(8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    idle(3);

    // reset mid dot-product
    beat(8'hFF, 0, 1, 0, 0, 8'h00, -1, 0, 0);
    beat(8'hFF, 0, 1, 0, 0, 8'h00, -1, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    q.delete();
    model_acc = 0;
    model_ovf = 0;
    model_w = 8'h00;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    beat(8'h0F, 0, 1, 1, 0, 8'h00, 4, 0, 0);
    idle(3);

    // randomized traffic with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) idle(1);
      else if (r == 1) load_w(8'($urandom));
      else begin
        bit m, l;
        m = $urandom_range(0, 1);
        l = ($urandom_range(0, 3) == 0);
        beat(8'($urandom), $urandom_range(0, 255), m, l,
             ($urandom_range(0, 9) == 0), 8'($urandom), -1, 0, 0);
      end
    end

    rdy_mode = 0;
    for (int n = 0; n < 50 && q.size() != 0; n++) idle(1);
    idle(2);
    chk("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_popcount_pe.md
Name: systolic_popcount_pe

Overview:
Next-generation binary-CNN processing element. Each beat it XNORs a LANES-wide activation vector against a stationary weight vector, popcounts the result, and adds it to an incoming partial sum. A 2-stage valid/ready pipeline supports pass-through (per-beat) and accumulate (multi-beat dot product) modes. Activations are forwarded to the neighbouring PE in the systolic row.

Parameters:
LANES, 8, bits processed per beat (>=1)
SUM_WIDTH, 8, partial-sum width; must be >= clog2(LANES+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset; all state cleared while low
weight_load  in  1  load weight_in into the weight register
weight_in  in  LANES  stationary weight vector
mode  in  1  0 = pass-through, 1 = accumulate; sampled with each accepted beat
in_valid  in  1  beat valid
in_ready  out  1  PE can accept a beat
act_in  in  LANES  activation vector
last_in  in  1  final beat of a dot product (accumulate mode)
partial_sum_in  in  SUM_WIDTH  upstream partial sum
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
partial_sum_out  out  SUM_WIDTH  result sum
act_out  out  LANES  activation forwarded with the result
last_out  out  1  last_in forwarded with the result
sat_out  out  1  result was clamped

Behaviour:
- Reset (reset=0, async): weights, accumulator, stage valids v1/v2, partial_sum_out, act_out, last_out and sat_out all 0. in_ready = 1 once reset is released.
- Handshake: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1. A beat is accepted when in_valid & in_ready. A result completes when out_valid & out_ready. Outputs are held stable while out_valid & !out_ready. No combinational path from in_valid to out_valid.
- Stage 1 (on acceptance): pop = popcount(~(act_in ^ weight_q)), width clog2(LANES+1). Register pop, partial_sum_in, act_in, last_in and mode.
- Stage 2 (when adv2 and v1):
  - mode 0: sum = partial_sum_in + pop. Emit every beat.
  - mode 1, not last: acc += pop. No output is produced and v2 is not set.
  - mode 1, last: sum = partial_sum_in + acc + pop. Emit, then clear acc to 0.
- Arithmetic: computed at SUM_WIDTH+2 bits. If the result exceeds 2^SUM_WIDTH-1, clamp to all-ones and set sat_out for that result. The accumulator saturates the same way and keeps a sticky overflow bit that ORs into sat_out of the closing beat.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Weights:
  - weight_load updates weight_q on the next edge.
  - An accepted beat in the same cycle as weight_load uses the old weights.
  - weight_load is allowed during a stall.
- Mode switch mid-dot-product (mode 0 beat while acc != 0): the beat is processed as pass-through and acc is unaffected.
- Boundaries:
  - All lanes match: pop = LANES.
  - No lanes match: pop = 0, and the partial sum passes through unchanged.
  - Single-beat accumulate (last_in on the first beat) equals the pass-through result.
- Reset asserted mid-operation drops in-flight beats and the accumulator. No spurious out_valid after release.

Optional Feature:
Macro SYSTOLIC_PE_LANE_MASK_EN.
- Defined: adds input port lane_mask [LANES]. The mask is registered with the weights on weight_load. Lanes with mask bit 0 contribute 0 to pop. The mask resets to all-ones.
- Undefined: no port, and all lanes count.

Test Plan:
1. Pass-through (LANES=8, SUM_WIDTH=8): weights 8'hF0; act 8'hF0, psum 3 -> 2 cycles later out_valid=1, partial_sum_out=11. Then act 8'h0F, psum 3 -> partial_sum_out=3.
2. Accumulate: weights 8'hFF; beats act 8'hFF, 8'h0F, 8'h01 (last), psum_in 10 on the last beat -> exactly one out_valid, partial_sum_out=10+8+4+1=23, last_out=1, acc cleared.
3. Saturation: psum 8'd250, act==weights -> partial_sum_out=255, sat_out=1. Next beat, psum 5 with pop 0 -> 5, sat_out=0.
4. Back-pressure: stream 5 pass-through beats with out_ready low for 4 cycles from cycle 3 -> in_ready drops after 2 beats buffered, outputs stay stable, all 5 results arrive in order with no loss or duplication.
5. Weight-load collision: weight_load=1 with weight_in=8'h00 in the same cycle as beat act 8'hFF (old weights 8'hFF) -> pop 8. The next identical beat -> pop 0.
6. Reset mid-dot-product: two accumulate beats, then reset low for 1 cycle -> outputs 0. A fresh single last beat, pop 4, psum 0 -> partial_sum_out=4 (no stale acc).
